// File: rtl/game_ctrl_n_if.sv
// Key/alarm-clear inputs and display outputs of the game controller.
// The master side drives keys; the slave side is the controller.
interface game_ctrl_n_if #(
  parameter int NCH = 10,
  parameter int CW  = 4
);
  localparam int SW  = $clog2(NCH + 1);
  localparam int CUW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [8:0]        key;
  logic              alarm_clr;
  logic [NCH*CW-1:0] status;
  logic [2:0]        state;
  logic [SW-1:0]     sel_count;
  logic [CUW-1:0]    cursor;
  logic              alarm;
  logic [7:0]        wraps;

  modport master (output key, alarm_clr,
                  input  status, state, sel_count, cursor, alarm, wraps);
  modport slave  (input  key, alarm_clr,
                  output status, state, sel_count, cursor, alarm, wraps);
endinterface

// File: rtl/game_ctrl_n.sv
// Multi-channel counter game controller: key-edge FSM, cursor moves, wrap alarm.
// Optional PAUSE state is built when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl_n_chan #(
  parameter int CW   = 4,
  parameter int MODV = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          load_one_i,
  input  logic          inc_i,
  output logic [CW-1:0] val_o
);
  logic [CW-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i)     val_d = load_one_i ? CW'(1) : '0;
    else if (inc_i) val_d = (val_q == CW'(MODV - 1)) ? '0 : val_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) val_q <= CW'(1);
    else        val_q <= val_d;

  assign val_o = val_q;
endmodule

module game_ctrl_n #(
  parameter int NCH       = 10,
  parameter int CW        = 4,
  parameter int MODV      = 10,
  parameter int GRID_COLS = 5,
  parameter int ALARM_CYC = 25_000_000
) (
  input logic         clk,
  input logic         rst_n,
  game_ctrl_n_if.slave bus
);
  localparam int SW  = $clog2(NCH + 1);
  localparam int CUW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(ALARM_CYC + 1);

  typedef enum logic [2:0] {
    ST_START = 3'd0, ST_HELP = 3'd1, ST_COUNT = 3'd2, ST_PLAY = 3'd3, ST_PAUSE = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [8:0]     key_q, key_d, kp;
  logic [SW-1:0]  sel_q, sel_d;
  logic [CUW-1:0] cursor_q, cursor_d;
  logic [7:0]     wraps_q, wraps_d;
  logic [AW-1:0]  alarm_q, alarm_d;
  logic           load_en, inc_en;
  logic [NCH-1:0][CW-1:0] chan_val;
  logic [CW-1:0]  cur_val;
  logic [31:0]    cur32, sel32;

  // Key history resets to ones so a key held through reset never pulses.
  assign key_d   = bus.key;
  assign kp      = bus.key & ~key_q;
  assign cur_val = chan_val[cursor_q];
  assign cur32   = 32'(cursor_q);
  assign sel32   = 32'(sel_q);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cursor_d = cursor_q;
    wraps_d  = wraps_q;
    alarm_d  = (alarm_q != '0) ? alarm_q - AW'(1) : '0;
    load_en  = 1'b0;
    inc_en   = 1'b0;
    case (state_q)
      ST_START: begin
        if (kp[1])      state_d = ST_HELP;
        else if (kp[0]) state_d = ST_COUNT;
      end
      ST_HELP: begin
        if (kp[2])      state_d = ST_START;
        else if (kp[0]) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (kp[3]) state_d = ST_START;
        else if (kp[8]) begin
          state_d  = ST_PLAY;
          load_en  = 1'b1;
          cursor_d = '0;
          wraps_d  = '0;
        end
        else if (kp[4]) sel_d = (sel_q == SW'(NCH)) ? SW'(1) : sel_q + SW'(1);
        else if (kp[5]) sel_d = (sel_q == SW'(1)) ? SW'(NCH) : sel_q - SW'(1);
      end
      ST_PLAY: begin
        if (kp[3]) begin
          state_d = ST_START;
          alarm_d = '0;
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (kp[2]) state_d = ST_PAUSE;
`endif
        else if (kp[8]) begin
          inc_en = 1'b1;
          if (cur_val == CW'(MODV - 1)) begin
            if (wraps_q != 8'hff) wraps_d = wraps_q + 8'd1;
            alarm_d = AW'(ALARM_CYC);
          end
        end
        else if (kp[4]) begin
          if (cur32 >= 32'(GRID_COLS)) cursor_d = CUW'(cur32 - 32'(GRID_COLS));
        end
        else if (kp[5]) begin
          if (cur32 + 32'(GRID_COLS) < sel32) cursor_d = CUW'(cur32 + 32'(GRID_COLS));
        end
        else if (kp[6]) cursor_d = (cursor_q == '0) ? CUW'(sel32 - 32'd1) : cursor_q - CUW'(1);
        else if (kp[7]) cursor_d = (cur32 == sel32 - 32'd1) ? '0 : cursor_q + CUW'(1);
      end
`ifdef GAME_CTRL_PAUSE_EN
      ST_PAUSE: begin
        if (kp[3])      state_d = ST_START;
        else if (kp[2]) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_START;
    endcase
    // Clear beats a same-cycle wrap reload.
    if (bus.alarm_clr) alarm_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_START;
      key_q    <= '1;
      sel_q    <= SW'(1);
      cursor_q <= '0;
      wraps_q  <= '0;
      alarm_q  <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      sel_q    <= sel_d;
      cursor_q <= cursor_d;
      wraps_q  <= wraps_d;
      alarm_q  <= alarm_d;
    end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    game_ctrl_n_chan #(.CW(CW), .MODV(MODV)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load_en),
      .load_one_i(SW'(i) < sel_q),
      .inc_i     (inc_en && (cursor_q == CUW'(i))),
      .val_o     (chan_val[i])
    );
  end

  assign bus.status    = chan_val;
  assign bus.state     = state_q;
  assign bus.sel_count = sel_q;
  assign bus.cursor    = cursor_q;
  assign bus.alarm     = (alarm_q != '0);
  assign bus.wraps     = wraps_q;
endmodule
